lc3_pipe_ctrl: RTL and testbench

- Central sequencing controller for the LC3 five-stage datapath: Fetch, Decode, Execute, Writeback, plus the PC-update path.
- Generates the per-stage enables (enable_fetch, enable_updatePC, enable_decode, enable_execute, enable_writeback) and the branch-taken strobe.
- Runs the data-memory access state machine.
- Sits beside the datapath and gates it: pipeline warm-up, control-flow drain stalls, load/store/indirect memory stalls.

---
 rtl/lc3_pipe_ctrl_if.sv | 49 ++++
 rtl/lc3_pipe_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_lc3_pipe_ctrl.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/lc3_pipe_ctrl_if.sv
// LC3 pipeline controller bundle: fetch/data handshakes, stage enables, memory FSM view.
// master = controller side, slave = datapath/memory side.
interface lc3_pipe_ctrl_if;
  logic       complete_instr;
  logic       complete_data;
  logic [3:0] imem_opcode;
  logic [3:0] exe_opcode;
  logic       nzp_ok;
  logic       enable_fetch;
  logic       enable_updatePC;
  logic       enable_decode;
  logic       enable_execute;
  logic       enable_writeback;
  logic       br_taken;
  logic [1:0] mem_state;
  logic       mem_err;

  modport master (
    input  complete_instr,
    input  complete_data,
    input  imem_opcode,
    input  exe_opcode,
    input  nzp_ok,
    output enable_fetch,
    output enable_updatePC,
    output enable_decode,
    output enable_execute,
    output enable_writeback,
    output br_taken,
    output mem_state,
    output mem_err
  );

  modport slave (
    output complete_instr,
    output complete_data,
    output imem_opcode,
    output exe_opcode,
    output nzp_ok,
    input  enable_fetch,
    input  enable_updatePC,
    input  enable_decode,
    input  enable_execute,
    input  enable_writeback,
    input  br_taken,
    input  mem_state,
    input  mem_err
  );
endinterface

// File: rtl/lc3_pipe_ctrl.sv
// LC3 five-stage sequencing controller: warm-up, branch drain, data-memory stalls.
// Define LC3_MEM_TIMEOUT_EN to add the memory watchdog and sticky mem_err.
module lc3_pipe_ctrl #(
  parameter int STALL_CYC = 3
`ifdef LC3_MEM_TIMEOUT_EN
  ,
  parameter int MEM_TIMEOUT = 16
`endif
) (
  input  logic            clock,
  input  logic            reset,
  lc3_pipe_ctrl_if.master bus
);

  localparam int STALL_EFF =
    (STALL_CYC < 2) ? 2 :
    (STALL_CYC > 7) ? 7 : STALL_CYC;

  typedef enum logic [2:0] {
    WARMUP,
    RUN,
    BR_DRAIN,
    MEM_IND,
    MEM_RD,
    MEM_WR
  } state_t;

  state_t     state, state_n;
  logic [3:0] v, v_n;
  logic [2:0] cnt, cnt_n;
  logic       br_cond, br_cond_n;
  logic       mem_wr, mem_wr_n;
  logic       ret_drain, ret_drain_n;

  logic       en_f, en_pc, en_d;
  logic       en_e, en_w;
  logic       br_tk;
  logic [1:0] ms;

  logic       cf_op, mem_op;
  logic       ld_op, st_op;
  logic       ldi_op, sti_op;
  logic       cf_go, mem_go;

`ifdef LC3_MEM_TIMEOUT_EN
  localparam int TW = $clog2(MEM_TIMEOUT + 1);
  logic [TW-1:0] timer;
  logic          timeout;
  logic          err;
`endif

  assign cf_op  = bus.imem_opcode inside
                  {4'b0000, 4'b1100, 4'b0100};
  assign ld_op  = bus.exe_opcode inside
                  {4'b0010, 4'b0110};
  assign st_op  = bus.exe_opcode inside
                  {4'b0011, 4'b0111};
  assign ldi_op = bus.exe_opcode == 4'b1010;
  assign sti_op = bus.exe_opcode == 4'b1011;
  assign mem_op = ld_op | st_op |
                  ldi_op | sti_op;

  // Per-state enables, memory view and next-state selection.
  always_comb begin
    state_n     = state;
    v_n         = v;
    cnt_n       = cnt;
    br_cond_n   = br_cond;
    mem_wr_n    = mem_wr;
    ret_drain_n = ret_drain;
    en_f        = 1'b0;
    en_pc       = 1'b0;
    en_d        = 1'b0;
    en_e        = 1'b0;
    en_w        = 1'b0;
    br_tk       = 1'b0;
    ms          = 2'b11;
    cf_go       = 1'b0;
    mem_go      = 1'b0;
`ifdef LC3_MEM_TIMEOUT_EN
    timeout     = 1'b0;
`endif

    unique case (state)
      WARMUP: begin
        en_f  = v[3];
        en_pc = v[3];
        en_d  = v[2];
        en_e  = v[1];
        en_w  = v[0];
        v_n   = {1'b1, v[3:1]};
        if (v_n == 4'b1111)
          state_n = RUN;
      end
      RUN: begin
        en_f  = bus.complete_instr;
        en_pc = bus.complete_instr;
        en_d  = v[2] & bus.complete_instr;
        en_e  = v[1] & bus.complete_instr;
        en_w  = v[0] & bus.complete_instr;
        if (bus.complete_instr)
          v_n = {1'b1, v[3:1]};
      end
      BR_DRAIN: begin
        en_d = v[2];
        en_e = v[1];
        en_w = v[0];
        v_n  = {1'b0, v[3:1]};
        if (cnt <= 3'd1) begin
          en_pc   = 1'b1;
          br_tk   = br_cond ? bus.nzp_ok : 1'b1;
          state_n = RUN;
        end else begin
          cnt_n = cnt - 3'd1;
        end
      end
      MEM_IND: begin
        ms = 2'b01;
        if (bus.complete_data)
          state_n = mem_wr ? MEM_WR : MEM_RD;
      end
      MEM_RD: begin
        ms = 2'b00;
        if (bus.complete_data) begin
          en_w    = 1'b1;
          state_n = ret_drain ? BR_DRAIN : RUN;
        end
      end
      MEM_WR: begin
        ms = 2'b10;
        if (bus.complete_data)
          state_n = ret_drain ? BR_DRAIN : RUN;
      end
      default: state_n = WARMUP;
    endcase

    mem_go = en_e & mem_op;
    cf_go  = en_f & cf_op;

    if (mem_go) begin
      unique case (1'b1)
        ldi_op, sti_op: state_n = MEM_IND;
        ld_op:          state_n = MEM_RD;
        default:        state_n = MEM_WR;
      endcase
      mem_wr_n    = sti_op;
      ret_drain_n = (state == BR_DRAIN) &&
                    (cnt != 3'd1);
    end else if (cf_go) begin
      state_n   = BR_DRAIN;
      cnt_n     = 3'(STALL_EFF);
      br_cond_n = bus.imem_opcode == 4'b0000;
    end

`ifdef LC3_MEM_TIMEOUT_EN
    if ((state inside {MEM_IND, MEM_RD, MEM_WR}) &&
        !bus.complete_data &&
        timer == TW'(MEM_TIMEOUT - 1)) begin
      timeout     = 1'b1;
      en_w        = 1'b0;
      ret_drain_n = 1'b0;
      state_n     = RUN;
    end
`endif
  end

  // Sequencer state, valid shift register and drain counter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= WARMUP;
      v         <= '0;
      cnt       <= '0;
      br_cond   <= 1'b0;
      mem_wr    <= 1'b0;
      ret_drain <= 1'b0;
    end else begin
      state     <= state_n;
      v         <= v_n;
      cnt       <= cnt_n;
      br_cond   <= br_cond_n;
      mem_wr    <= mem_wr_n;
      ret_drain <= ret_drain_n;
    end
  end

`ifdef LC3_MEM_TIMEOUT_EN
  // Per-state memory watchdog and sticky error flag.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      timer <= '0;
      err   <= 1'b0;
    end else begin
      if ((state inside {MEM_IND, MEM_RD, MEM_WR}) &&
          state_n == state)
        timer <= timer + TW'(1);
      else
        timer <= '0;
      if (timeout)
        err <= 1'b1;
    end
  end

  assign bus.mem_err = err;
`else
  assign bus.mem_err = 1'b0;
`endif

  assign bus.enable_fetch     = en_f;
  assign bus.enable_updatePC  = en_pc;
  assign bus.enable_decode    = en_d;
  assign bus.enable_execute   = en_e;
  assign bus.enable_writeback = en_w;
  assign bus.br_taken         = br_tk;
  assign bus.mem_state        = ms;

endmodule

// File: tb/tb_lc3_pipe_ctrl.sv
// Directed bench for lc3_pipe_ctrl with STALL_CYC = 3.
// Expected vector: {fetch, updatePC, decode, execute, writeback, br_taken, mem_state, mem_err}.
module tb_lc3_pipe_ctrl;
  logic clock = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   passed = 0;

  lc3_pipe_ctrl_if bus ();

  lc3_pipe_ctrl dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic nxt();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [4:0] en,
                     input logic br, input logic [1:0] ms,
                     input logic err);
    logic [8:0] obs;
    logic [8:0] exp;
    #1;
    obs = {bus.enable_fetch, bus.enable_updatePC,
           bus.enable_decode, bus.enable_execute,
           bus.enable_writeback, bus.br_taken,
           bus.mem_state, bus.mem_err};
    exp = {en, br, ms, err};
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %b want %b", tag, obs, exp);
  endtask

  initial begin
    bus.complete_instr = 1'b1;
    bus.complete_data  = 1'b0;
    bus.imem_opcode    = 4'h1;
    bus.exe_opcode     = 4'h1;
    bus.nzp_ok         = 1'b0;

    nxt(); nxt();
    chk("reset", 5'b00000, 0, 2'b11, 0);
    reset = 1'b1;
    chk("cyc0", 5'b00000, 0, 2'b11, 0);
    nxt(); chk("wu_fetch", 5'b11000, 0, 2'b11, 0);
    nxt(); chk("wu_decode", 5'b11100, 0, 2'b11, 0);
    nxt(); chk("wu_exec", 5'b11110, 0, 2'b11, 0);
    nxt(); chk("wu_wb", 5'b11111, 0, 2'b11, 0);

    nxt(); bus.complete_instr = 1'b0;
    chk("freeze", 5'b00000, 0, 2'b11, 0);
    nxt(); bus.complete_instr = 1'b1;
    chk("unfreeze", 5'b11111, 0, 2'b11, 0);

    nxt(); bus.imem_opcode = 4'h0; bus.nzp_ok = 1'b1;
    chk("br_trig", 5'b11111, 0, 2'b11, 0);
    nxt(); bus.imem_opcode = 4'h1;
    chk("br_d1", 5'b00111, 0, 2'b11, 0);
    nxt(); chk("br_d2", 5'b00111, 0, 2'b11, 0);
    nxt(); chk("br_d3", 5'b01011, 1, 2'b11, 0);
    nxt(); chk("br_resume", 5'b11001, 0, 2'b11, 0);
    nxt(); chk("refill1", 5'b11000, 0, 2'b11, 0);
    nxt(); chk("refill2", 5'b11100, 0, 2'b11, 0);
    nxt(); chk("refill3", 5'b11110, 0, 2'b11, 0);
    nxt(); chk("refill4", 5'b11111, 0, 2'b11, 0);

    nxt(); bus.imem_opcode = 4'h0; bus.nzp_ok = 1'b0;
    chk("brn_trig", 5'b11111, 0, 2'b11, 0);
    nxt(); bus.imem_opcode = 4'h1;
    chk("brn_d1", 5'b00111, 0, 2'b11, 0);
    nxt(); chk("brn_d2", 5'b00111, 0, 2'b11, 0);
    nxt(); chk("brn_d3", 5'b01011, 0, 2'b11, 0);
    nxt(); chk("brn_resume", 5'b11001, 0, 2'b11, 0);
    repeat (4) nxt();
    chk("brn_full", 5'b11111, 0, 2'b11, 0);

    nxt(); bus.imem_opcode = 4'hC;
    chk("jmp_trig", 5'b11111, 0, 2'b11, 0);
    nxt(); bus.imem_opcode = 4'h1;
    chk("jmp_d1", 5'b00111, 0, 2'b11, 0);
    nxt(); nxt();
    chk("jmp_d3", 5'b01011, 1, 2'b11, 0);
    nxt(); chk("jmp_resume", 5'b11001, 0, 2'b11, 0);
    repeat (4) nxt();
    chk("jmp_full", 5'b11111, 0, 2'b11, 0);

    nxt(); bus.exe_opcode = 4'hA;
    chk("ldi_trig", 5'b11111, 0, 2'b11, 0);
    nxt(); bus.exe_opcode = 4'h1;
    chk("ldi_ind1", 5'b00000, 0, 2'b01, 0);
    nxt(); bus.complete_data = 1'b1;
    chk("ldi_ind2", 5'b00000, 0, 2'b01, 0);
    nxt(); bus.complete_data = 1'b0;
    chk("ldi_rd1", 5'b00000, 0, 2'b00, 0);
    nxt(); chk("ldi_rd2", 5'b00000, 0, 2'b00, 0);
    nxt(); bus.complete_data = 1'b1;
    chk("ldi_rd3_wb", 5'b00001, 0, 2'b00, 0);
    nxt(); bus.complete_data = 1'b0;
    chk("ldi_done", 5'b11111, 0, 2'b11, 0);

    nxt(); bus.exe_opcode = 4'h2; bus.complete_data = 1'b1;
    chk("ld_trig_cd", 5'b11111, 0, 2'b11, 0);
    nxt(); bus.exe_opcode = 4'h1;
    chk("ld_rd_min", 5'b00001, 0, 2'b00, 0);
    nxt(); bus.complete_data = 1'b0;
    chk("ld_done", 5'b11111, 0, 2'b11, 0);

    nxt(); bus.exe_opcode = 4'hB;
    bus.imem_opcode = 4'h0; bus.nzp_ok = 1'b1;
    chk("sti_br_trig", 5'b11111, 0, 2'b11, 0);
    nxt(); bus.exe_opcode = 4'h1; bus.complete_data = 1'b1;
    chk("sti_ind", 5'b00000, 0, 2'b01, 0);
    nxt(); chk("sti_wr", 5'b00000, 0, 2'b10, 0);
    nxt(); bus.complete_data = 1'b0;
    chk("br_again", 5'b11111, 0, 2'b11, 0);
    nxt(); bus.imem_opcode = 4'h1;
    chk("br2_d1", 5'b00111, 0, 2'b11, 0);
    nxt(); nxt();
    chk("br2_d3", 5'b01011, 1, 2'b11, 0);
    nxt(); chk("br2_resume", 5'b11001, 0, 2'b11, 0);

    nxt(); bus.imem_opcode = 4'h0;
    chk("part_trig", 5'b11000, 0, 2'b11, 0);
    nxt(); bus.imem_opcode = 4'h1;
    chk("part_d1", 5'b00100, 0, 2'b11, 0);
    reset = 1'b0;
    chk("rst_drain", 5'b00000, 0, 2'b11, 0);
    nxt(); reset = 1'b1;
    chk("rst1_cyc0", 5'b00000, 0, 2'b11, 0);
    nxt(); chk("rst1_wu", 5'b11000, 0, 2'b11, 0);
    repeat (3) nxt();
    chk("rst1_full", 5'b11111, 0, 2'b11, 0);

    nxt(); bus.exe_opcode = 4'h2;
    chk("ld2_trig", 5'b11111, 0, 2'b11, 0);
    nxt(); bus.exe_opcode = 4'h1;
    chk("ld2_rd", 5'b00000, 0, 2'b00, 0);
    reset = 1'b0;
    chk("rst_mem", 5'b00000, 0, 2'b11, 0);
    nxt(); reset = 1'b1;
    chk("rst2_cyc0", 5'b00000, 0, 2'b11, 0);
    nxt(); chk("rst2_wu", 5'b11000, 0, 2'b11, 0);
    repeat (3) nxt();
    chk("rst2_full", 5'b11111, 0, 2'b11, 0);

`ifdef LC3_MEM_TIMEOUT_EN
    nxt(); bus.exe_opcode = 4'h2;
    chk("to_trig", 5'b11111, 0, 2'b11, 0);
    bus.exe_opcode = 4'h1;
    for (int i = 0; i < 16; i++) begin
      nxt();
      chk("to_wait", 5'b00000, 0, 2'b00, 0);
    end
    nxt(); chk("to_err", 5'b11111, 0, 2'b11, 1);
    nxt(); chk("to_sticky", 5'b11111, 0, 2'b11, 1);
    reset = 1'b0;
    chk("to_rst", 5'b00000, 0, 2'b11, 0);
    reset = 1'b1;
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
